// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU op codes,
// response FSM encodings and the op legality helper.
package alu_share_arbiter_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_FULL  = 1'b1;

    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Existing combinational ALU; output is only meaningful for legal op codes.
module alu_share_arbiter_alu
    import alu_share_arbiter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   op,
    output logic [N-1:0] y
);

    // Operation decode; SLT is an unsigned compare, zero-extended
    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_SLT:  y = {{(N-1){1'b0}}, (a < b)};
            OP_NOR:  y = ~(a | b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two valid/ready requesters, with a
// single registered, id-tagged response slot that supports backpressure.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic [3:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    input  logic [3:0]   req1_op,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic         rsp_err
);

    logic         state_r;
    logic         rr_last_r;
    logic         rsp_id_r;
    logic [N-1:0] rsp_result_r;
    logic         rsp_err_r;

    logic         grant_s;
    logic         can_accept_s;
    logic         accept_s;
    logic [N-1:0] alu_a_s;
    logic [N-1:0] alu_b_s;
    logic [3:0]   alu_op_s;
    logic [N-1:0] alu_y_s;
    logic         legal_s;

    // Grant selection: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~rr_last_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign can_accept_s = (state_r == ST_EMPTY) || rsp_ready;
    assign req0_ready   = !reset && can_accept_s && req0_valid && (grant_s == 1'b0);
    assign req1_ready   = !reset && can_accept_s && req1_valid && (grant_s == 1'b1);
    assign accept_s     = req0_ready || req1_ready;

    // Steer the granted requester's operands into the shared ALU
    always_comb begin
        alu_a_s  = req0_a;
        alu_b_s  = req0_b;
        alu_op_s = req0_op;
        if (grant_s) begin
            alu_a_s  = req1_a;
            alu_b_s  = req1_b;
            alu_op_s = req1_op;
        end else begin
            alu_a_s  = req0_a;
            alu_b_s  = req0_b;
            alu_op_s = req0_op;
        end
    end

    alu_share_arbiter_alu #(.N(N)) u_alu (
        .a  (alu_a_s),
        .b  (alu_b_s),
        .op (alu_op_s),
        .y  (alu_y_s)
    );

    assign legal_s = op_is_legal(alu_op_s);

    // Response slot FSM and round-robin pointer; a reload while draining keeps FULL
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_EMPTY;
            rr_last_r    <= 1'b1;
            rsp_id_r     <= 1'b0;
            rsp_result_r <= '0;
            rsp_err_r    <= 1'b0;
        end else if (accept_s) begin
            state_r      <= ST_FULL;
            rr_last_r    <= grant_s;
            rsp_id_r     <= grant_s;
            rsp_result_r <= legal_s ? alu_y_s : '0;
            rsp_err_r    <= ~legal_s;
        end else if ((state_r == ST_FULL) && rsp_ready) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_r;
        end
    end

    assign rsp_valid  = (state_r == ST_FULL);
    assign rsp_id     = rsp_id_r;
    assign rsp_result = rsp_result_r;
    assign rsp_err    = rsp_err_r;

endmodule
